pe_fp8_mx: RTL and testbench

- Parametrised successor to the FP8 systolic processing element.
- Multiplies two FP8 operands, in E4M3 or E5M2 selected per operand pair, and accumulates into a signed fixed-point accumulator.
- Multiply-align and accumulate are in two pipeline stages; the accumulator saturates instead of wrapping.
- Operands and valid forward to the east/south neighbours; a psum chain shifts accumulator results out of the array.

---
 rtl/pe_fp8_mx.sv | 199 +++++++++++++++++++
 tb/tb_pe_fp8_mx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_fp8_mx.sv
// rtl/pe_fp8_mx.sv - FP8 (E4M3/E5M2) multiply-accumulate systolic processing element
//
// Purpose:
//   Multiplies two FP8 operands (format chosen per pair by fmt_in) into a
//   signed fixed-point product with FRAC_BITS fractional bits. The product is
//   registered (stage 1) and then added into a saturating ACC_W-bit
//   accumulator (stage 2). Operands are forwarded east/south, and a psum
//   register either captures the accumulator or shifts from the neighbour.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous accumulator/flag clear
//   valid_in   a_in/b_in/fmt_in carry a valid operand pair
//   fmt_in     0 = E4M3, 1 = E5M2
//   a_in/b_in  FP8 operands
//   a_out/b_out/valid_out/fmt_out  inputs delayed by one cycle
//   acc_out    accumulator value
//   sat_flag   sticky saturation flag
//   nan_flag   sticky NaN/Inf operand flag
//   cap        load psum_out from the accumulator
//   shift      load psum_out from psum_in (cap wins)
//   psum_in    psum chain input
//   psum_out   psum chain register

module pe_fp8_mx #(
   parameter int ACC_W     = 24,
   parameter int FRAC_BITS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             valid_in,
   input  logic             fmt_in,
   input  logic [7:0]       a_in,
   input  logic [7:0]       b_in,
   output logic [7:0]       a_out,
   output logic [7:0]       b_out,
   output logic             valid_out,
   output logic             fmt_out,
   output logic [ACC_W-1:0] acc_out,
   output logic             sat_flag,
   output logic             nan_flag,
   input  logic             cap,
   input  logic             shift,
   input  logic [ACC_W-1:0] psum_in,
   output logic [ACC_W-1:0] psum_out
);

   // Holds the shifted 8-bit product for any left shift below ACC_W.
   localparam int WIDE = ACC_W + 8;

   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef struct packed {
      logic              sign;
      logic              special;  // NaN or Inf
      logic signed [6:0] exp;      // unbiased exponent
      logic [3:0]        mant;     // hidden bit + 3 fraction bits
   } fp8_dec_t;

   function automatic fp8_dec_t decode(input logic fmt, input logic [7:0] x);
      fp8_dec_t d;
      d.sign = x[7];
      if (!fmt) begin
         d.special = (x[6:0] == 7'h7F);
         if (x[6:3] == 4'd0) begin
            d.exp  = -7'sd6;
            d.mant = {1'b0, x[2:0]};
         end else begin
            d.exp  = $signed({3'b000, x[6:3]}) - 7'sd7;
            d.mant = {1'b1, x[2:0]};
         end
      end else begin
         d.special = (x[6:2] == 5'h1F);
         // E5M2 has 2 mantissa bits; pad to the common 3-bit fraction.
         if (x[6:2] == 5'd0) begin
            d.exp  = -7'sd14;
            d.mant = {1'b0, x[1:0], 1'b0};
         end else begin
            d.exp  = $signed({2'b00, x[6:2]}) - 7'sd15;
            d.mant = {1'b1, x[1:0], 1'b0};
         end
      end
      return d;
   endfunction

   fp8_dec_t          da, db;
   logic [7:0]        prod;
   logic signed [7:0] exp_p;
   logic signed [9:0] shift_l;
   logic [9:0]        shift_u;
   logic [9:0]        rsh;
   logic [WIDE-1:0]   wide;
   logic              ovf;
   logic [ACC_W-2:0]  mag;
   logic              special;
   logic [ACC_W-1:0]  p_next;
   logic              s1_sat;
   logic              s1_nan;

   logic              v1;
   logic [ACC_W-1:0]  p1;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W:0]    sum;
   logic              s2_ovf;
   logic [ACC_W-1:0]  acc_next;

   // Stage 1: decode, multiply and align the product to the accumulator grid.
   always_comb begin
      da      = decode(fmt_in, a_in);
      db      = decode(fmt_in, b_in);
      prod    = 8'(da.mant) * 8'(db.mant);
      exp_p   = $signed({da.exp[6], da.exp}) + $signed({db.exp[6], db.exp});
      // Product carries 6 fraction bits; move it onto FRAC_BITS.
      shift_l = $signed(10'(FRAC_BITS - 6)) + $signed({{2{exp_p[7]}}, exp_p});
      shift_u = shift_l;
      rsh     = 10'(-shift_l);
      wide    = '0;
      ovf     = 1'b0;
      if (!shift_l[9]) begin
         if (shift_u >= 10'(ACC_W)) begin
            ovf = (prod != 8'd0);
         end else begin
            wide = {{(WIDE-8){1'b0}}, prod} << shift_u;
            ovf  = |wide[WIDE-1:ACC_W-1];
         end
      end else if (rsh < 10'd8) begin
         // Right shift of a magnitude truncates toward zero.
         wide = {{(WIDE-8){1'b0}}, prod} >> rsh;
      end
      mag     = ovf ? {(ACC_W-1){1'b1}} : wide[ACC_W-2:0];
      special = da.special | db.special;
      if (special) begin
         p_next = '0;
      end else if (da.sign ^ db.sign) begin
         p_next = -{1'b0, mag};
      end else begin
         p_next = {1'b0, mag};
      end
      s1_sat = valid_in & ovf & ~special;
      s1_nan = valid_in & special;
   end

   // Stage 2: saturating accumulate with one guard bit.
   always_comb begin
      sum      = {acc[ACC_W-1], acc} + {p1[ACC_W-1], p1};
      s2_ovf   = sum[ACC_W] ^ sum[ACC_W-1];
      acc_next = sum[ACC_W-1:0];
      if (s2_ovf) begin
         acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out     <= '0;
         b_out     <= '0;
         valid_out <= 1'b0;
         fmt_out   <= 1'b0;
         v1        <= 1'b0;
         p1        <= '0;
         acc       <= '0;
         sat_flag  <= 1'b0;
         nan_flag  <= 1'b0;
         psum_out  <= '0;
      end else begin
         a_out     <= a_in;
         b_out     <= b_in;
         valid_out <= valid_in;
         fmt_out   <= fmt_in;
         v1        <= valid_in;
         if (valid_in) begin
            p1 <= p_next;
         end
         if (clear) begin
            // Drops the product in stage 1; a pair entering now still flags.
            acc      <= '0;
            sat_flag <= s1_sat;
            nan_flag <= s1_nan;
         end else begin
            if (v1) begin
               acc <= acc_next;
            end
            sat_flag <= sat_flag | s1_sat | (v1 & s2_ovf);
            nan_flag <= nan_flag | s1_nan;
         end
         if (cap) begin
            psum_out <= acc;
         end else if (shift) begin
            psum_out <= psum_in;
         end
      end
   end

   assign acc_out = acc;

endmodule

// File: tb/tb_pe_fp8_mx.sv
// tb/tb_pe_fp8_mx.sv - self-checking bench for pe_fp8_mx with a real-valued reference model

module tb_pe_fp8_mx;

   localparam int ACC_W     = 24;
   localparam int FRAC_BITS = 8;
   localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
   localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             valid_in;
   logic             fmt_in;
   logic [7:0]       a_in;
   logic [7:0]       b_in;
   logic [7:0]       a_out;
   logic [7:0]       b_out;
   logic             valid_out;
   logic             fmt_out;
   logic [ACC_W-1:0] acc_out;
   logic             sat_flag;
   logic             nan_flag;
   logic             cap;
   logic             shift;
   logic [ACC_W-1:0] psum_in;
   logic [ACC_W-1:0] psum_out;

   pe_fp8_mx #(.ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in),
      .fmt_in(fmt_in), .a_in(a_in), .b_in(b_in), .a_out(a_out),
      .b_out(b_out), .valid_out(valid_out), .fmt_out(fmt_out),
      .acc_out(acc_out), .sat_flag(sat_flag), .nan_flag(nan_flag),
      .cap(cap), .shift(shift), .psum_in(psum_in), .psum_out(psum_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint p;
      bit     sat;
      bit     nan;
   } exp_t;

   exp_t   q[$];
   int     n_tests = 0;
   int     n_fail  = 0;

   longint m_acc = 0;
   bit     m_sat = 0;
   bit     m_nan = 0;
   bit     m_v1  = 0;
   bit     pend  = 0;
   int     n_pop = 0;
   exp_t   e_cur;
   longint m_sum;
   logic [31:0] m_acc24;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic real pow2(input int n);
      real r = 1.0;
      for (int i = 0; i < n; i++) r = r * 2.0;
      for (int i = 0; i > n; i--) r = r / 2.0;
      return r;
   endfunction

   function automatic real fp8_abs(input bit fmt, input logic [7:0] x, output bit special);
      int e;
      real m;
      if (!fmt) begin
         e = int'(x[6:3]);
         m = real'(int'(x[2:0])) / 8.0;
         special = (x[6:0] == 7'h7F);
         return (e == 0) ? m * pow2(-6) : (1.0 + m) * pow2(e - 7);
      end
      e = int'(x[6:2]);
      m = real'(int'(x[1:0])) / 4.0;
      special = (e == 31);
      return (e == 0) ? m * pow2(-14) : (1.0 + m) * pow2(e - 15);
   endfunction

   function automatic exp_t model_prod(input bit fmt, input logic [7:0] a, input logic [7:0] b);
      exp_t r;
      bit   sa, sb;
      real  va, vb, m;
      va = fp8_abs(fmt, a, sa);
      vb = fp8_abs(fmt, b, sb);
      r.p = 0;
      r.sat = 1'b0;
      r.nan = sa | sb;
      if (!r.nan) begin
         m = va * vb * pow2(FRAC_BITS);
         if (m >= real'(ACC_MAX) + 1.0) begin
            r.p = ACC_MAX;
            r.sat = 1'b1;
         end else begin
            r.p = longint'($rtoi(m));
         end
         if (a[7] ^ b[7]) r.p = -r.p;
      end
      return r;
   endfunction

   // Scoreboard consumer: mirrors the two-stage timing at the bench level.
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         q.delete();
         m_acc = 0; m_sat = 0; m_nan = 0; m_v1 = 0; pend = 0;
      end else begin
         pend = 0;
         if (m_v1 && q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
         end else if (clear) begin
            if (m_v1) void'(q.pop_front());
            m_acc = 0; m_sat = 0; m_nan = 0;
         end else if (m_v1) begin
            e_cur = q.pop_front();
            m_sum = m_acc + e_cur.p;
            if (m_sum > ACC_MAX) begin m_sum = ACC_MAX; m_sat = 1; end
            if (m_sum < ACC_MIN) begin m_sum = ACC_MIN; m_sat = 1; end
            m_acc = m_sum;
            pend = 1;
         end
         if (valid_in && q.size() > 0) begin
            m_sat = m_sat | q[q.size()-1].sat;
            m_nan = m_nan | q[q.size()-1].nan;
         end
         m_v1 = valid_in;
      end
   end

   initial forever begin
      @(negedge clk);
      if (pend) begin
         n_pop++;
         m_acc24 = {8'h00, m_acc[23:0]};
         chk($sformatf("acc[%0d]", n_pop), {8'h00, acc_out}, m_acc24);
         chk($sformatf("sat[%0d]", n_pop), {31'd0, sat_flag}, {31'd0, m_sat});
         chk($sformatf("nan[%0d]", n_pop), {31'd0, nan_flag}, {31'd0, m_nan});
      end
   end

   task automatic pair(input bit f, input logic [7:0] a, input logic [7:0] b);
      valid_in = 1'b1;
      fmt_in   = f;
      a_in     = a;
      b_in     = b;
      q.push_back(model_prod(f, a, b));
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      clear    = 1'b0;
      cap      = 1'b0;
      shift    = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_a_out"}, {24'd0, a_out}, 32'd0);
      chk({tag, "_b_out"}, {24'd0, b_out}, 32'd0);
      chk({tag, "_valid_out"}, {31'd0, valid_out}, 32'd0);
      chk({tag, "_fmt_out"}, {31'd0, fmt_out}, 32'd0);
      chk({tag, "_acc"}, {8'd0, acc_out}, 32'd0);
      chk({tag, "_sat"}, {31'd0, sat_flag}, 32'd0);
      chk({tag, "_nan"}, {31'd0, nan_flag}, 32'd0);
      chk({tag, "_psum"}, {8'd0, psum_out}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0; fmt_in = 1'b0;
      a_in = 8'h5A; b_in = 8'hA5; cap = 1'b0; shift = 1'b0; psum_in = 24'h123456;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      idle(1);

      // 1.0 x 1.0 and pass-through
      pair(1'b0, 8'h38, 8'h38);
      chk("pass_a", {24'd0, a_out}, 32'h38);
      chk("pass_b", {24'd0, b_out}, 32'h38);
      chk("pass_valid", {31'd0, valid_out}, 32'd1);
      idle(1);
      chk("pass_valid_low", {31'd0, valid_out}, 32'd0);
      chk("acc_one", {8'd0, acc_out}, 32'h000100);
      idle(1);

      // back-to-back: 2.0 x -1.5, then 1.0 x 1.0
      do_clear();
      pair(1'b0, 8'h40, 8'hBC);
      pair(1'b0, 8'h38, 8'h38);
      idle(3);
      chk("acc_b2b", {8'd0, acc_out}, 32'h00FFFE00);

      // denormals
      do_clear();
      pair(1'b0, 8'h01, 8'h7E);
      pair(1'b0, 8'h01, 8'h01);
      idle(3);
      chk("acc_denorm", {8'd0, acc_out}, 32'h0000E0);

      // E5M2 saturation, then clear
      do_clear();
      pair(1'b1, 8'h7B, 8'h7B);
      pair(1'b1, 8'h3C, 8'h3C);
      chk("pass_fmt", {31'd0, fmt_out}, 32'd1);
      idle(3);
      chk("acc_sat", {8'd0, acc_out}, 32'h7FFFFF);
      chk("sat_flag_set", {31'd0, sat_flag}, 32'd1);
      do_clear();
      chk("acc_after_clear", {8'd0, acc_out}, 32'd0);
      chk("sat_after_clear", {31'd0, sat_flag}, 32'd0);

      // NaN operand, then a product dropped by clear
      pair(1'b0, 8'h38, 8'h38);
      pair(1'b0, 8'h7F, 8'h38);
      idle(3);
      chk("nan_flag_set", {31'd0, nan_flag}, 32'd1);
      chk("acc_nan_unchanged", {8'd0, acc_out}, 32'h000100);
      pair(1'b0, 8'h38, 8'h38);
      do_clear();
      idle(2);
      chk("acc_dropped", {8'd0, acc_out}, 32'd0);
      chk("nan_after_clear", {31'd0, nan_flag}, 32'd0);

      // random pairs, both formats, with occasional gaps
      for (int i = 0; i < 24; i++) begin
         pair(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(3);

      // psum chain
      do_clear();
      pair(1'b0, 8'h38, 8'h38);
      idle(3);
      psum_in = 24'h123456;
      cap = 1'b1;
      @(negedge clk);
      cap = 1'b0;
      chk("psum_cap", {8'd0, psum_out}, 32'h000100);
      shift = 1'b1;
      @(negedge clk);
      shift = 1'b0;
      chk("psum_shift", {8'd0, psum_out}, 32'h123456);
      idle(1);
      chk("psum_hold", {8'd0, psum_out}, 32'h123456);
      cap = 1'b1;
      shift = 1'b1;
      @(negedge clk);
      cap = 1'b0;
      shift = 1'b0;
      chk("psum_cap_prio", {8'd0, psum_out}, 32'h000100);

      // asynchronous reset with a product in flight
      pair(1'b1, 8'h40, 8'h40);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      a_in = 8'h00;
      b_in = 8'h00;
      fmt_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      chk("acc_no_partial", {8'd0, acc_out}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
